// File: rtl/regfile_param.sv
// regfile_param: parametrised 2R1W register file with byte-enable writes,
// registered reads, write-to-read bypass and a sequential clear engine.
// Ports: clk; rst (async, active-high); clear in / busy out (zero sweep);
// address_w, enable_w, be_w, In (write port);
// address_a/b, enable_a/b (read ports);
// OutA/OutB with valid_a/valid_b (registered read data + 1-cycle pulse).
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             busy,
  input  logic [AW-1:0]    address_w,
  input  logic             enable_w,
  input  logic [NB-1:0]    be_w,
  input  logic [WIDTH-1:0] In,
  input  logic [AW-1:0]    address_a,
  input  logic [AW-1:0]    address_b,
  input  logic             enable_a,
  input  logic             enable_b,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             valid_a,
  output logic             valid_b
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] OutA_q, OutB_q;
  logic [WIDTH-1:0] OutA_d, OutB_d;
  logic             valid_a_q, valid_b_q;

  // No reset on the array so it can map onto RAM;
  // the sweep provides the zeroing instead.
  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic in_rng(
    input logic [AW-1:0] a
  );
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic is_zero(
    input logic [AW-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic busy_w;
  assign busy_w = (state_q == S_CLEAR);

  // A clear request in IDLE wins over a write in the same cycle.
  logic wr_ok;
  assign wr_ok = !busy_w && !clear && enable_w
              && in_rng(address_w) && !is_zero(address_w);

  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  assign wr_idx = in_rng(address_w) ? address_w : '0;

  // Read-modify-write merge, also used as the bypass value.
  always_comb begin
    wr_data = mem[wr_idx];
    for (int k = 0; k < NB; k++) begin
      if (be_w[k]) wr_data[8*k +: 8] = In[8*k +: 8];
    end
  end

  // Single physical write port shared by the sweep and normal writes.
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;

  always_comb begin
    mem_we = wr_ok;
    mem_wa = wr_idx;
    mem_wd = wr_data;
    if (busy_w) begin
      mem_we = 1'b1;
      mem_wa = idx_q;
      mem_wd = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Next read data for each port.
  always_comb begin
    OutA_d = '0;
    if (!busy_w && in_rng(address_a)
        && !is_zero(address_a)) begin
      if (wr_ok && address_a == address_w)
        OutA_d = wr_data;
      else
        OutA_d = mem[address_a];
    end
  end

  always_comb begin
    OutB_d = '0;
    if (!busy_w && in_rng(address_b)
        && !is_zero(address_b)) begin
      if (wr_ok && address_b == address_w)
        OutB_d = wr_data;
      else
        OutB_d = mem[address_b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      idx_q     <= '0;
      OutA_q    <= '0;
      OutB_q    <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (clear) begin
            state_q <= S_CLEAR;
            idx_q   <= '0;
          end
        end
        S_CLEAR: begin
          if (idx_q == LAST) state_q <= S_IDLE;
          idx_q <= idx_q + AW'(1);
        end
      endcase
      valid_a_q <= enable_a;
      valid_b_q <= enable_b;
      if (enable_a) OutA_q <= OutA_d;
      if (enable_b) OutB_q <= OutB_d;
    end
  end

  assign busy    = busy_w;
  assign OutA    = OutA_q;
  assign OutB    = OutB_q;
  assign valid_a = valid_a_q;
  assign valid_b = valid_b_q;

endmodule
